led_int_handler: RTL

LED_INT_HANDLER -- requirements
Module: led_int_handler

---
 rtl/led_pkg.sv | 7 +
 rtl/sat_acc.sv | 23 ++
 rtl/led_int_handler.sv | 112 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared widths and FSM state encoding for the LED interrupt handler
package led_pkg;
  localparam int DIV_W  = 12;
  localparam int CNT_W  = 32;
  localparam int MISS_W = 16;
  typedef enum logic [2:0] {IDLE, SERVICE, CLEAR, WAIT_DEASSERT, ERROR} state_e;
endpackage

// File: rtl/sat_acc.sv
// sat_acc: accumulator of width W that adds an IW-bit value per enabled cycle and sticks at all-ones
// Ports: clk/rst clock and sync reset; en_i add strobe; val_i addend; acc_o accumulated value.
module sat_acc #(
  parameter int W  = 16,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [IW-1:0] val_i,
  output logic [W-1:0]  acc_o
);
  logic [W-1:0] acc_q, acc_d;
  logic [IW:0]  sum;
  // one spare bit above IW keeps the carry; any bit above W means overflow
  assign sum   = {{(IW + 1 - W){1'b0}}, acc_q} + {1'b0, val_i};
  assign acc_d = en_i ? (|sum[IW:W] ? '1 : sum[W-1:0]) : acc_q;
  assign acc_o = acc_q;
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
endmodule

// File: rtl/led_int_handler.sv
// led_int_handler: services LED-counter interrupts and forwards divider writes
// Ports: clk100/rst clock and sync reset; enable_i gates new service entry;
//   div_i/div_valid_i/div_ready_o divider write handshake; div_o/wren_o divider and strobe;
//   led_int_i/int_cnt_i interrupt level and count; int_clr_o clear pulse;
//   svc_cnt_o/miss_cnt_o/last_cnt_o statistics; timeout_o sticky clear-timeout flag.
module led_int_handler
  import led_pkg::*;
#(
  parameter int SVC_DLY     = 4,
  parameter int CLR_TIMEOUT = 16
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              div_valid_i,
  output logic              div_ready_o,
  output logic [DIV_W-1:0]  div_o,
  output logic              wren_o,
  input  logic              led_int_i,
  input  logic [CNT_W-1:0]  int_cnt_i,
  output logic              int_clr_o,
  output logic [CNT_W-1:0]  svc_cnt_o,
  output logic [MISS_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0]  last_cnt_o,
  output logic              timeout_o
);
  localparam logic [15:0] SVC_END = 16'(SVC_DLY);
  // cnt counts cycles since the clear, so the flag shows exactly CLR_TIMEOUT cycles after it
  localparam logic [15:0] TO_END  = 16'(CLR_TIMEOUT - 1);
  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] svc_q, svc_d, last_q, last_d, gap;
  logic             wren_q, first_q, first_d, to_q, to_d, miss_en;
  assign gap = int_cnt_i - last_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    svc_d       = svc_q;
    last_d      = last_q;
    first_d     = first_q;
    to_d        = to_q;
    miss_en     = 1'b0;
    div_ready_o = (state_q == IDLE) && div_valid_i;
    case (state_q)
      IDLE: begin
        if (div_valid_i) div_d = div_i;
        else if (enable_i && led_int_i) begin
          state_d = SERVICE;
          cnt_d   = 16'd1;
          last_d  = int_cnt_i;
          first_d = 1'b0;
          miss_en = !first_q && (gap > CNT_W'(1));
        end
      end
      SERVICE: begin
        if (cnt_q == SVC_END) state_d = CLEAR;
        else cnt_d = cnt_q + 16'd1;
      end
      CLEAR: begin
        svc_d   = svc_q + CNT_W'(1);
        cnt_d   = 16'd1;
        state_d = WAIT_DEASSERT;
      end
      WAIT_DEASSERT: begin
        if (!led_int_i) state_d = IDLE;
        else if (cnt_q == TO_END) begin
          state_d = ERROR;
          to_d    = 1'b1;
        end
        else cnt_d = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      svc_q   <= '0;
      last_q  <= '0;
      first_q <= 1'b1;
      to_q    <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      svc_q   <= svc_d;
      last_q  <= last_d;
      first_q <= first_d;
      to_q    <= to_d;
      wren_q  <= div_ready_o;
    end
  end
  sat_acc #(.W(MISS_W), .IW(CNT_W)) u_miss (
    .clk   (clk100),
    .rst   (rst),
    .en_i  (miss_en),
    .val_i (gap - CNT_W'(1)),
    .acc_o (miss_cnt_o)
  );
  assign div_o      = div_q;
  assign wren_o     = wren_q;
  assign int_clr_o  = state_q == CLEAR;
  assign svc_cnt_o  = svc_q;
  assign last_cnt_o = last_q;
  assign timeout_o  = to_q;
endmodule
